// File: rtl/kb_scan_decoder.sv
// kb_scan_decoder
//   Brings PS/2 received bytes into the system clock domain, parses Set-2
//   scan-code prefixes (E0 extended, F0 break, E1 pause) into key events and
//   queues them in a first-word-fall-through FIFO.
//
// Optional build macro:
//   KB_TYPEMATIC_FILTER_EN - suppress repeated make events of the last held key.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_ps2_done   byte-received level from the PS/2 receiver (asynchronous)
//   i_ps2_data   received byte, stable while i_ps2_done is high
//   i_rd_en      pop the FIFO head (ignored when empty)
//   i_clr_ovf    clear the sticky overflow flag
//   o_valid      FIFO not empty
//   o_key_code   head event scan code
//   o_extended   head event had an E0 prefix
//   o_break      head event is a key release
//   o_overflow   sticky: an event was dropped on a full FIFO
//   o_count      number of events held
module kb_scan_decoder #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ps2_done,
    input  logic [7:0]       i_ps2_data,
    input  logic             i_rd_en,
    input  logic             i_clr_ovf,
    output logic             o_valid,
    output logic [7:0]       o_key_code,
    output logic             o_extended,
    output logic             o_break,
    output logic             o_overflow,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk,
        StSkip
    } state_e;

    // ------------------------------------------------------------------
    // Done-level synchronizer and single-cycle byte strobe
    // ------------------------------------------------------------------
    logic sync_s1, sync_s2, sync_s3;
    logic byte_stb;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_s1 <= 1'b0;
            sync_s2 <= 1'b0;
            sync_s3 <= 1'b0;
        end else begin
            sync_s1 <= i_ps2_done;
            sync_s2 <= sync_s1;
            sync_s3 <= sync_s2;
        end
    end

    // Rising edge of the synchronized level: one strobe per done pulse.
    assign byte_stb = sync_s2 & ~sync_s3;

    // ------------------------------------------------------------------
    // Prefix parser
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_brk;
    logic       idle_discard;

    // Controller responses and error codes never form key events.
    assign idle_discard = i_ps2_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA,
                                             8'hFC, 8'hFD, 8'hFE, 8'hFF};

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        ev_valid = 1'b0;
        ev_code  = i_ps2_data;
        ev_ext   = 1'b0;
        ev_brk   = 1'b0;
        if (byte_stb) begin
            case (state_q)
                StIdle: begin
                    if (i_ps2_data == 8'hE0) begin
                        state_d = StExt;
                    end else if (i_ps2_data == 8'hF0) begin
                        state_d = StBrk;
                    end else if (i_ps2_data == 8'hE1) begin
                        // Pause is E1 followed by seven more bytes.
                        state_d = StSkip;
                        skip_d  = 3'd7;
                    end else if (!idle_discard) begin
                        ev_valid = 1'b1;
                    end
                end
                StExt: begin
                    if (i_ps2_data == 8'hF0) begin
                        state_d = StExtBrk;
                    end else if (i_ps2_data == 8'hE0) begin
                        state_d = StExt;
                    end else begin
                        // E0 12 is the fake shift emitted around some keys.
                        ev_valid = (i_ps2_data != 8'h12);
                        ev_ext   = 1'b1;
                        state_d  = StIdle;
                    end
                end
                StBrk: begin
                    ev_valid = 1'b1;
                    ev_brk   = 1'b1;
                    state_d  = StIdle;
                end
                StExtBrk: begin
                    ev_valid = (i_ps2_data != 8'h12);
                    ev_ext   = 1'b1;
                    ev_brk   = 1'b1;
                    state_d  = StIdle;
                end
                StSkip: begin
                    if (skip_q == 3'd1) begin
                        ev_valid = 1'b1;
                        ev_code  = 8'hE1;
                        skip_d   = 3'd0;
                        state_d  = StIdle;
                    end else begin
                        skip_d = skip_q - 3'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    skip_d  = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            skip_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional typematic repeat filter
    // ------------------------------------------------------------------
    logic push;

`ifdef KB_TYPEMATIC_FILTER_EN
    logic [8:0] last_make_q;
    logic       last_valid_q;
    logic       last_match;

    assign last_match = last_valid_q && (last_make_q == {ev_code, ev_ext});
    assign push       = ev_valid && !(!ev_brk && last_match);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_make_q  <= 9'd0;
            last_valid_q <= 1'b0;
        end else if (ev_valid) begin
            if (!ev_brk && !last_match) begin
                last_make_q  <= {ev_code, ev_ext};
                last_valid_q <= 1'b1;
            end else if (ev_brk && last_match) begin
                last_valid_q <= 1'b0;
            end
        end
    end
`else
    assign push = ev_valid;
`endif

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic             full, pop, wr, drop;
    logic [9:0]       head;

    assign full = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop  = i_rd_en && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr   = push && (!full || pop);
    assign drop = push && full && !pop;

    always_ff @(posedge i_clk) begin
        if (wr) begin
            mem[wr_ptr_q] <= {ev_code, ev_ext, ev_brk};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (wr && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !wr) begin
                count_q <= count_q - CNT_W'(1);
            end
            // A drop outranks a simultaneous clear.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (i_clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign head       = mem[rd_ptr_q];
    assign o_valid    = (count_q != '0);
    // Head fields are forced to zero while empty so reset presents all-zero outputs.
    assign o_key_code = o_valid ? head[9:2] : 8'h00;
    assign o_extended = o_valid & head[1];
    assign o_break    = o_valid & head[0];
    assign o_overflow = ovf_q;
    assign o_count    = count_q;

endmodule

// File: tb/tb_kb_scan_decoder.sv
// tb_kb_scan_decoder
//   Self-checking bench for kb_scan_decoder: directed scenarios followed by a
//   randomized byte/pop mix, all compared against a prefix-flag reference model.
module tb_kb_scan_decoder;

    localparam int unsigned DEPTH = 8;

    logic       clk;
    logic       rst_n;
    logic       ps2_done;
    logic [7:0] ps2_data;
    logic       rd_en;
    logic       clr_ovf;
    logic       valid;
    logic [7:0] key_code;
    logic       extended;
    logic       brk;
    logic       overflow;
    logic [3:0] count;

    kb_scan_decoder #(
        .FIFO_DEPTH(DEPTH),
        .CNT_W     (4)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_ps2_done(ps2_done),
        .i_ps2_data(ps2_data),
        .i_rd_en   (rd_en),
        .i_clr_ovf (clr_ovf),
        .o_valid   (valid),
        .o_key_code(key_code),
        .o_extended(extended),
        .o_break   (brk),
        .o_overflow(overflow),
        .o_count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pending prefix flags plus a queue of events
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    ev_t        mq[$];
    bit         m_ovf;
    bit         m_ext;
    bit         m_brk;
    int         m_skip;
    bit         m_lv;
    logic [8:0] m_last;

    function automatic void m_reset();
        mq.delete();
        m_ovf  = 0;
        m_ext  = 0;
        m_brk  = 0;
        m_skip = 0;
        m_lv   = 0;
        m_last = '0;
    endfunction

    function automatic void m_emit(logic [7:0] c, bit e, bit b);
        ev_t ev;
`ifdef KB_TYPEMATIC_FILTER_EN
        if (!b) begin
            if (m_lv && m_last == {c, e}) return;
            m_last = {c, e};
            m_lv   = 1;
        end else if (m_lv && m_last == {c, e}) begin
            m_lv = 0;
        end
`endif
        ev.code = c;
        ev.ext  = e;
        ev.brk  = b;
        if (mq.size() < DEPTH) mq.push_back(ev);
        else m_ovf = 1;
    endfunction

    function automatic void m_byte(logic [7:0] b);
        if (m_skip > 0) begin
            m_skip--;
            if (m_skip == 0) m_emit(8'hE1, 0, 0);
        end else if (m_brk) begin
            if (!(m_ext && b == 8'h12)) m_emit(b, m_ext, 1);
            m_ext = 0;
            m_brk = 0;
        end else if (m_ext) begin
            if (b == 8'hF0) m_brk = 1;
            else if (b != 8'hE0) begin
                if (b != 8'h12) m_emit(b, 1, 0);
                m_ext = 0;
            end
        end else begin
            case (b)
                8'hE0: m_ext = 1;
                8'hF0: m_brk = 1;
                8'hE1: m_skip = 7;
                8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: ;
                default: m_emit(b, 0, 0);
            endcase
        end
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(count), 32'(mq.size()));
        check({tag, ".valid"}, 32'(valid), 32'(mq.size() != 0));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        if (mq.size() > 0) begin
            check({tag, ".code"}, 32'(key_code), 32'(mq[0].code));
            check({tag, ".ext"}, 32'(extended), 32'(mq[0].ext));
            check({tag, ".brk"}, 32'(brk), 32'(mq[0].brk));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        ps2_data = b;
        ps2_done = 1'b1;
        repeat (hold) @(negedge clk);
        ps2_done = 1'b0;
        repeat (4) @(negedge clk);
        m_byte(b);
    endtask

    task automatic pop_one();
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic drain(input string tag);
        while (mq.size() > 0) begin
            check_state(tag);
            pop_one();
        end
        check_state(tag);
    endtask

    logic [7:0] tbl [14];

    initial begin
        tbl = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h1C, 8'h1C, 8'h75, 8'hAA,
                8'hFA, 8'h00, 8'h14, 8'h77, 8'h1B, 8'h74};
        ps2_done = 1'b0;
        ps2_data = 8'h00;
        rd_en    = 1'b0;
        clr_ovf  = 1'b0;
        rst_n    = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst.valid", 32'(valid), 0);
        check("rst.code", 32'(key_code), 0);
        check("rst.ext", 32'(extended), 0);
        check("rst.brk", 32'(brk), 0);
        check("rst.ovf", 32'(overflow), 0);
        check("rst.count", 32'(count), 0);

        // Single make with latency: valid rises after the 3rd edge
        ps2_data = 8'h1C;
        ps2_done = 1'b1;
        @(posedge clk); #1 check("lat.e1", 32'(valid), 0);
        @(posedge clk); #1 check("lat.e2", 32'(valid), 0);
        @(posedge clk); #1 check("lat.e3", 32'(valid), 1);
        check("lat.count", 32'(count), 1);
        @(negedge clk);
        ps2_done = 1'b0;
        repeat (4) @(negedge clk);
        m_byte(8'h1C);
        check_state("make");
        drain("make");

        // Extended break
        send_byte(8'hE0, 2);
        send_byte(8'hF0, 2);
        check("extbrk.prefix", 32'(count), 0);
        send_byte(8'h75, 3);
        check("extbrk.count", 32'(count), 1);
        check("extbrk.code", 32'(key_code), 32'h75);
        check("extbrk.ext", 32'(extended), 1);
        check("extbrk.brk", 32'(brk), 1);
        drain("extbrk");

        // Pause sequence then a normal key
        begin
            logic [7:0] pseq [8];
            pseq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
            for (int i = 0; i < 8; i++) send_byte(pseq[i], 2);
        end
        check("pause.count", 32'(count), 1);
        check("pause.code", 32'(key_code), 32'hE1);
        send_byte(8'h1C, 2);
        check_state("pause");
        drain("pause");

        // Overflow, simultaneous push/pop when full, clear
        do_reset();
        for (int i = 0; i < 9; i++) send_byte(8'h15 + 8'(i), 2);
        check("ovf.count", 32'(count), 8);
        check("ovf.flag", 32'(overflow), 1);
        check_state("ovf");
        @(negedge clk);
        ps2_data = 8'h21;
        ps2_done = 1'b1;
        repeat (2) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en    = 1'b0;
        ps2_done = 1'b0;
        repeat (4) @(negedge clk);
        void'(mq.pop_front());
        m_byte(8'h21);
        check("pushpop.count", 32'(count), 8);
        check_state("pushpop");
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        m_ovf = 0;
        check("clr.ovf", 32'(overflow), 0);
        drain("ovfdrain");

        // Typematic repeats
        do_reset();
        send_byte(8'h1C, 2);
        send_byte(8'h1C, 2);
        send_byte(8'h1C, 2);
        send_byte(8'hF0, 2);
        send_byte(8'h1C, 2);
`ifdef KB_TYPEMATIC_FILTER_EN
        check("tm.count", 32'(count), 2);
`else
        check("tm.count", 32'(count), 4);
`endif
        drain("tm");

        // Reset mid-prefix discards the E0
        send_byte(8'hE0, 2);
        do_reset();
        send_byte(8'h74, 2);
        check("rstpfx.code", 32'(key_code), 32'h74);
        check("rstpfx.ext", 32'(extended), 0);
        drain("rstpfx");

        // Long done pulse yields a single event
        send_byte(8'h2A, 100);
        check("long.count", 32'(count), 1);
        drain("long");

        // Randomized mix of bytes and pops
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 6) begin
                if ($urandom_range(0, 4) == 0) send_byte(8'($urandom), $urandom_range(2, 6));
                else send_byte(tbl[$urandom_range(0, 13)], $urandom_range(2, 6));
            end else begin
                pop_one();
            end
            check_state("rand");
        end
        drain("randdrain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
